// File: rtl/flow_pifo_ctrl_pkg.sv
// Shared flow_pifo definitions: storage geometry, per-flow capacity and the
// priority / flow-id types used on the PIFO interfaces.
package flow_pifo_ctrl_pkg;

    localparam int unsigned PIFO_NUM_FLOWS        = 16;
    localparam int unsigned PIFO_PRIO_W           = 8;
    localparam int unsigned PIFO_FLOW_W           = $clog2(PIFO_NUM_FLOWS);

    // One PIFO-set entry plus the prefetch buffer plus the per-flow FIFO bank.
    localparam int unsigned PREFETCH_BUFFER_DEPTH = 3;
    localparam int unsigned FIFO_DEPTH            = 8;
    localparam int unsigned PIFO_FLOW_CAPACITY    = 1 + PREFETCH_BUFFER_DEPTH + FIFO_DEPTH;

    typedef logic [PIFO_PRIO_W-1:0] Priority;
    typedef logic [PIFO_FLOW_W-1:0] FlowId;

endpackage

// File: rtl/flow_pifo_ctrl_rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first requester at or after the
// pointer (wrapping); the pointer moves past the winner only when a grant is made.
module rr_arbiter #(
    parameter int unsigned N = 4
) (
    input  logic         i_clk,
    input  logic         i_reset,
    input  logic [N-1:0] i_req,
    output logic [N-1:0] o_grant
);

    localparam int unsigned PTR_W = (N > 1) ? $clog2(N) : 1;

    logic [PTR_W-1:0] r_ptr;
    logic [PTR_W-1:0] w_ptr_next;
    logic [PTR_W-1:0] w_idx;
    logic             w_found;

    // Search from the pointer, wrapping modulo N; first requester wins.
    always_comb begin
        o_grant    = '0;
        w_found    = 1'b0;
        w_idx      = '0;
        w_ptr_next = r_ptr;
        for (int unsigned k = 0; k < N; k++) begin
            w_idx = PTR_W'((32'(r_ptr) + k) % N);
            if (!w_found && i_req[w_idx]) begin
                w_found        = 1'b1;
                o_grant[w_idx] = 1'b1;
                w_ptr_next     = PTR_W'((32'(w_idx) + 1) % N);
            end
        end
    end

    // Pointer register; holds when nothing is granted.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_ptr <= '0;
        end else begin
            r_ptr <= w_ptr_next;
        end
    end

endmodule

// File: rtl/flow_pifo_ctrl.sv
// Front-end controller for flow_pifo: round-robin enqueue arbitration with
// per-flow capacity guarding, occupancy tracking, registered dequeue results
// and a flush mode that drains the PIFO.
module flow_pifo_ctrl
    import flow_pifo_ctrl_pkg::*;
#(
    parameter int unsigned NUM_PORTS     = 4,
    parameter int unsigned NUM_FLOWS     = PIFO_NUM_FLOWS,
    parameter int unsigned FLOW_CAPACITY = PIFO_FLOW_CAPACITY,
    parameter int unsigned PRIO_W        = PIFO_PRIO_W,
    parameter int unsigned FLOW_W        = $clog2(NUM_FLOWS)
) (
    input  logic                                           clk,
    input  logic                                           reset,
    input  logic [NUM_PORTS-1:0]                           i__enq_valid,
    input  logic [NUM_PORTS*PRIO_W-1:0]                    i__enq_priority,
    input  logic [NUM_PORTS*FLOW_W-1:0]                    i__enq_flow_id,
    output logic [NUM_PORTS-1:0]                           o__enq_ready,
    input  logic                                           i__deq_req,
    input  logic                                           i__flush,
    output logic                                           o__deq_valid,
    output logic [PRIO_W-1:0]                              o__deq_priority,
    output logic [FLOW_W-1:0]                              o__deq_flow_id,
    output logic                                           o__pifo_enqueue,
    output logic [PRIO_W-1:0]                              o__pifo_enqueue_priority,
    output logic [FLOW_W-1:0]                              o__pifo_enqueue_flow_id,
    output logic                                           o__pifo_dequeue,
    input  logic [PRIO_W-1:0]                              i__pifo_dequeue_priority,
    input  logic [FLOW_W-1:0]                              i__pifo_dequeue_flow_id,
    output logic [$clog2(NUM_FLOWS*FLOW_CAPACITY+1)-1:0]   o__occupancy,
    output logic                                           o__flush_done
);

    localparam int unsigned CNT_W = $clog2(FLOW_CAPACITY + 1);
    localparam int unsigned OCC_W = $clog2(NUM_FLOWS * FLOW_CAPACITY + 1);

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } state_t;

    state_t                r_state;
    state_t                w_state_next;

    logic [CNT_W-1:0]      r_flow_count [NUM_FLOWS];
    logic [OCC_W-1:0]      r_occupancy;

    logic [NUM_PORTS-1:0]  w_eligible;
    logic [NUM_PORTS-1:0]  w_grant;
    logic [FLOW_W-1:0]     w_port_flow;
    logic                  w_enq;
    logic                  w_deq;
    logic                  w_nonempty;
    logic                  w_flush_done;
    logic [PRIO_W-1:0]     w_enq_priority;
    logic [FLOW_W-1:0]     w_enq_flow_id;
    logic [NUM_FLOWS-1:0]  w_flow_inc;
    logic [NUM_FLOWS-1:0]  w_flow_dec;

    logic                  r_deq_valid;
    logic [PRIO_W-1:0]     r_deq_priority;
    logic [FLOW_W-1:0]     r_deq_flow_id;

    assign w_nonempty = (r_occupancy != '0);

    // A port is eligible only in RUN and while its flow has room, judged on
    // the registered count (a same-cycle dequeue gives no credit).
    always_comb begin
        w_eligible  = '0;
        w_port_flow = '0;
        for (int unsigned p = 0; p < NUM_PORTS; p++) begin
            w_port_flow   = i__enq_flow_id[p*FLOW_W +: FLOW_W];
            w_eligible[p] = i__enq_valid[p] && (r_state == ST_RUN) &&
                            (r_flow_count[w_port_flow] < CNT_W'(FLOW_CAPACITY));
        end
    end

    rr_arbiter #(
        .N (NUM_PORTS)
    ) u_rr_arbiter (
        .i_clk   (clk),
        .i_reset (reset),
        .i_req   (w_eligible),
        .o_grant (w_grant)
    );

    assign w_enq = |w_grant;

    // Steer the granted port's priority and flow id onto the PIFO enqueue slot.
    always_comb begin
        w_enq_priority = '0;
        w_enq_flow_id  = '0;
        for (int unsigned p = 0; p < NUM_PORTS; p++) begin
            if (w_grant[p]) begin
                w_enq_priority = i__enq_priority[p*PRIO_W +: PRIO_W];
                w_enq_flow_id  = i__enq_flow_id[p*FLOW_W +: FLOW_W];
            end
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state, dequeue issue and flush completion; never dequeue when empty.
    always_comb begin
        w_state_next = r_state;
        w_deq        = 1'b0;
        w_flush_done = 1'b0;
        case (r_state)
            ST_RUN: begin
                w_deq = i__deq_req && w_nonempty;
                if (i__flush) begin
                    w_state_next = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                w_deq = w_nonempty;
                if (!w_nonempty) begin
                    w_state_next = ST_RUN;
                    w_flush_done = 1'b1;
                end
            end
            default: begin
                w_state_next = ST_RUN;
            end
        endcase
    end

    // One-hot per-flow increment / decrement strobes for this cycle.
    always_comb begin
        w_flow_inc = '0;
        w_flow_dec = '0;
        if (w_enq) begin
            w_flow_inc[w_enq_flow_id] = 1'b1;
        end
        if (w_deq) begin
            w_flow_dec[i__pifo_dequeue_flow_id] = 1'b1;
        end
    end

    // Per-flow and total occupancy; enqueue+dequeue on the same flow cancels.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned f = 0; f < NUM_FLOWS; f++) begin
                r_flow_count[f] <= '0;
            end
            r_occupancy <= '0;
        end else begin
            for (int unsigned f = 0; f < NUM_FLOWS; f++) begin
                if (w_flow_inc[f] && !w_flow_dec[f]) begin
                    r_flow_count[f] <= r_flow_count[f] + CNT_W'(1);
                end else if (w_flow_dec[f] && !w_flow_inc[f]) begin
                    r_flow_count[f] <= r_flow_count[f] - CNT_W'(1);
                end
            end
            if (w_enq && !w_deq) begin
                r_occupancy <= r_occupancy + OCC_W'(1);
            end else if (w_deq && !w_enq) begin
                r_occupancy <= r_occupancy - OCC_W'(1);
            end
        end
    end

    // Capture the PIFO head on each dequeue; valid for exactly one cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_deq_valid    <= 1'b0;
            r_deq_priority <= '0;
            r_deq_flow_id  <= '0;
        end else begin
            r_deq_valid <= w_deq;
            if (w_deq) begin
                r_deq_priority <= i__pifo_dequeue_priority;
                r_deq_flow_id  <= i__pifo_dequeue_flow_id;
            end
        end
    end

    assign o__enq_ready             = w_grant;
    assign o__pifo_enqueue          = w_enq;
    assign o__pifo_enqueue_priority = w_enq_priority;
    assign o__pifo_enqueue_flow_id  = w_enq_flow_id;
    assign o__pifo_dequeue          = w_deq;
    assign o__occupancy             = r_occupancy;
    assign o__flush_done            = w_flush_done;
    assign o__deq_valid             = r_deq_valid;
    assign o__deq_priority          = r_deq_priority;
    assign o__deq_flow_id           = r_deq_flow_id;

endmodule

// File: tb/tb_flow_pifo_ctrl.sv
// Testbench for flow_pifo_ctrl: a queue-based stand-in for flow_pifo drives the
// head inputs, and a behavioural model predicts every output each cycle.
module tb_flow_pifo_ctrl;

    localparam int NP  = 4;
    localparam int NF  = 16;
    localparam int CAP = 12;
    localparam int PW  = 8;
    localparam int FW  = 4;
    localparam int OW  = $clog2(NF*CAP+1);

    logic               clk = 1'b0;
    logic               reset;
    logic [NP-1:0]      enq_valid;
    logic [NP*PW-1:0]   enq_prio;
    logic [NP*FW-1:0]   enq_flow;
    logic [NP-1:0]      enq_ready;
    logic               deq_req;
    logic               flush;
    logic               deq_valid;
    logic [PW-1:0]      deq_prio;
    logic [FW-1:0]      deq_flow;
    logic               pifo_enq;
    logic [PW-1:0]      pifo_enq_prio;
    logic [FW-1:0]      pifo_enq_flow;
    logic               pifo_deq;
    logic [PW-1:0]      pifo_prio;
    logic [FW-1:0]      pifo_flow;
    logic [OW-1:0]      occupancy;
    logic               flush_done;

    flow_pifo_ctrl #(
        .NUM_PORTS     (NP),
        .NUM_FLOWS     (NF),
        .FLOW_CAPACITY (CAP),
        .PRIO_W        (PW),
        .FLOW_W        (FW)
    ) dut (
        .clk                      (clk),
        .reset                    (reset),
        .i__enq_valid             (enq_valid),
        .i__enq_priority          (enq_prio),
        .i__enq_flow_id           (enq_flow),
        .o__enq_ready             (enq_ready),
        .i__deq_req               (deq_req),
        .i__flush                 (flush),
        .o__deq_valid             (deq_valid),
        .o__deq_priority          (deq_prio),
        .o__deq_flow_id           (deq_flow),
        .o__pifo_enqueue          (pifo_enq),
        .o__pifo_enqueue_priority (pifo_enq_prio),
        .o__pifo_enqueue_flow_id  (pifo_enq_flow),
        .o__pifo_dequeue          (pifo_deq),
        .i__pifo_dequeue_priority (pifo_prio),
        .i__pifo_dequeue_flow_id  (pifo_flow),
        .o__occupancy             (occupancy),
        .o__flush_done            (flush_done)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Stand-in PIFO contents: head is the lowest priority, oldest first on ties.
    typedef struct {
        int prio;
        int flow;
    } pkt_t;
    pkt_t pifo_q[$];

    // Reference model state.
    int m_cnt [NF];
    int m_occ;
    int m_ptr;
    bit m_flush;
    bit m_dv;
    int m_dp;
    int m_df;

    // Per-cycle predictions and observations shared between drive and tick.
    int   e_win, e_flow;
    bit   e_deq;
    bit   c_rs, c_fs;
    int   c_head, c_hprio, c_hflow;
    logic d_enq, d_deq;
    int   d_eprio, d_eflow;

    typedef struct {
        logic [NP-1:0]    v;
        logic [NP*PW-1:0] pr;
        logic [NP*FW-1:0] fl;
        logic [NP-1:0]    exp_ready;
        int               exp_occ;
    } vec_t;
    vec_t vecs [5];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int head_idx();
        int best;
        best = -1;
        foreach (pifo_q[i]) begin
            if (best < 0 || pifo_q[i].prio < pifo_q[best].prio) best = i;
        end
        return best;
    endfunction

    task automatic model_clear();
        pifo_q.delete();
        for (int f = 0; f < NF; f++) m_cnt[f] = 0;
        m_occ = 0; m_ptr = 0; m_flush = 0; m_dv = 0; m_dp = 0; m_df = 0;
    endtask

    task automatic do_reset();
        enq_valid = '0; enq_prio = '0; enq_flow = '0;
        deq_req = 1'b0; flush = 1'b0; pifo_prio = '0; pifo_flow = '0;
        reset = 1'b1;
        @(posedge clk);
        @(posedge clk);
        model_clear();
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Apply one cycle of inputs (called just after a falling edge), predict
    // and compare all outputs 1 time unit later.
    task automatic drive(input logic [NP-1:0] v, input logic [NP*PW-1:0] pr,
                         input logic [NP*FW-1:0] fl, input logic dq,
                         input logic fs, input logic rs);
        int p;
        int f;
        enq_valid = v; enq_prio = pr; enq_flow = fl;
        deq_req = dq; flush = fs; reset = rs;
        c_rs = rs; c_fs = fs;
        c_head = head_idx();
        if (c_head >= 0) begin
            c_hprio = pifo_q[c_head].prio;
            c_hflow = pifo_q[c_head].flow;
        end else begin
            c_hprio = 0;
            c_hflow = 0;
        end
        pifo_prio = PW'(c_hprio);
        pifo_flow = FW'(c_hflow);
        e_win  = -1;
        e_flow = 0;
        for (int k = 0; k < NP; k++) begin
            p = (m_ptr + k) % NP;
            f = int'(fl[p*FW +: FW]);
            if (e_win < 0 && v[p] && !m_flush && m_cnt[f] < CAP) begin
                e_win  = p;
                e_flow = f;
            end
        end
        e_deq = (m_flush || dq) && (m_occ != 0);
        #1;
        d_enq   = pifo_enq;
        d_deq   = pifo_deq;
        d_eprio = int'(pifo_enq_prio);
        d_eflow = int'(pifo_enq_flow);
        chk("grant", 64'(enq_ready), (e_win < 0) ? 64'd0 : (64'd1 << e_win));
        chk("pifo_enqueue", 64'(pifo_enq), 64'(e_win >= 0));
        if (e_win >= 0) begin
            chk("enq_priority", 64'(pifo_enq_prio), 64'(pr[e_win*PW +: PW]));
            chk("enq_flow", 64'(pifo_enq_flow), 64'(e_flow));
        end
        chk("pifo_dequeue", 64'(pifo_deq), 64'(e_deq));
        chk("occupancy", 64'(occupancy), 64'(m_occ));
        chk("flush_done", 64'(flush_done), 64'(m_flush && m_occ == 0));
        chk("deq_valid", 64'(deq_valid), 64'(m_dv));
        if (m_dv) begin
            chk("deq_priority", 64'(deq_prio), 64'(m_dp));
            chk("deq_flow", 64'(deq_flow), 64'(m_df));
        end
    endtask

    // Advance one clock; update the PIFO stand-in from what the DUT issued and
    // the model from its own predictions.
    task automatic tick();
        int old_occ;
        old_occ = m_occ;
        @(posedge clk);
        if (c_rs) begin
            model_clear();
        end else begin
            if (d_deq && c_head >= 0) pifo_q.delete(c_head);
            if (d_enq) pifo_q.push_back('{prio: d_eprio, flow: d_eflow});
            if (e_win >= 0) begin
                m_cnt[e_flow]++;
                m_occ++;
                m_ptr = (e_win + 1) % NP;
            end
            if (e_deq) begin
                m_cnt[c_hflow]--;
                m_occ--;
                m_dp = c_hprio;
                m_df = c_hflow;
            end
            m_dv = e_deq;
            if (!m_flush) m_flush = c_fs;
            else if (old_occ == 0) m_flush = 0;
        end
        @(negedge clk);
    endtask

    task automatic idle();
        drive('0, '0, '0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [NP*PW-1:0] rpr;
        logic [NP*FW-1:0] rfl;
        int grants, deqs, dones, done_at;
        bit done_seen;

        vecs[0] = '{v: 4'hF, pr: 32'h40302010, fl: 16'h3210, exp_ready: 4'b0001, exp_occ: 0};
        vecs[1] = '{v: 4'hF, pr: 32'h40302010, fl: 16'h3210, exp_ready: 4'b0010, exp_occ: 1};
        vecs[2] = '{v: 4'hF, pr: 32'h40302010, fl: 16'h3210, exp_ready: 4'b0100, exp_occ: 2};
        vecs[3] = '{v: 4'hF, pr: 32'h40302010, fl: 16'h3210, exp_ready: 4'b1000, exp_occ: 3};
        vecs[4] = '{v: 4'hF, pr: 32'h40302010, fl: 16'h3210, exp_ready: 4'b0001, exp_occ: 4};

        // Reset state.
        do_reset();
        idle();
        chk("rst_ready", 64'(enq_ready), 64'd0);
        chk("rst_occ", 64'(occupancy), 64'd0);
        chk("rst_deq_valid", 64'(deq_valid), 64'd0);
        chk("rst_deq_prio", 64'(deq_prio), 64'd0);
        chk("rst_deq_flow", 64'(deq_flow), 64'd0);
        chk("rst_flush_done", 64'(flush_done), 64'd0);
        tick();

        // Round-robin rotation over four distinct flows.
        for (int i = 0; i < 5; i++) begin
            drive(vecs[i].v, vecs[i].pr, vecs[i].fl, 1'b0, 1'b0, 1'b0);
            chk("tbl_ready", 64'(enq_ready), 64'(vecs[i].exp_ready));
            chk("tbl_occ", 64'(occupancy), 64'(vecs[i].exp_occ));
            tick();
        end

        // Flow capacity: 12 accepted, 13th held until a dequeue frees a slot.
        do_reset();
        for (int i = 0; i < CAP; i++) begin
            drive(4'b0010, NP*PW'($urandom), 16'h0050, 1'b0, 1'b0, 1'b0);
            chk("cap_fill_ready", 64'(enq_ready), 64'd2);
            tick();
        end
        drive(4'b0010, 32'h00000900, 16'h0050, 1'b0, 1'b0, 1'b0);
        chk("cap_full_ready", 64'(enq_ready), 64'd0);
        chk("cap_full_occ", 64'(occupancy), 64'd12);
        tick();
        drive(4'b0010, 32'h00000900, 16'h0050, 1'b1, 1'b0, 1'b0);
        chk("cap_nocredit_ready", 64'(enq_ready), 64'd0);
        chk("cap_deq", 64'(pifo_deq), 64'd1);
        tick();
        drive(4'b0010, 32'h00000900, 16'h0050, 1'b0, 1'b0, 1'b0);
        chk("cap_resume_ready", 64'(enq_ready), 64'd2);
        tick();

        // Simultaneous enqueue and dequeue on flow 2 at count 3.
        do_reset();
        drive(4'b0001, 32'd30, 16'h0002, 1'b0, 1'b0, 1'b0); tick();
        drive(4'b0001, 32'd20, 16'h0002, 1'b0, 1'b0, 1'b0); tick();
        drive(4'b0001, 32'd10, 16'h0002, 1'b0, 1'b0, 1'b0); tick();
        drive(4'b0001, 32'd50, 16'h0002, 1'b1, 1'b0, 1'b0);
        chk("same_enq", 64'(pifo_enq), 64'd1);
        chk("same_deq", 64'(pifo_deq), 64'd1);
        tick();
        idle();
        chk("same_occ", 64'(occupancy), 64'd3);
        chk("same_deq_valid", 64'(deq_valid), 64'd1);
        chk("same_deq_prio", 64'(deq_prio), 64'd10);
        chk("same_deq_flow", 64'(deq_flow), 64'd2);
        tick();

        // Dequeue request while empty is dropped.
        do_reset();
        drive('0, '0, '0, 1'b1, 1'b0, 1'b0);
        chk("empty_pifo_deq", 64'(pifo_deq), 64'd0);
        tick();
        idle();
        chk("empty_deq_valid", 64'(deq_valid), 64'd0);
        tick();

        // Flush with 5 packets resident.
        do_reset();
        for (int i = 0; i < 5; i++) begin
            drive(4'b0001, NP*PW'($urandom), NP*FW'(i), 1'b0, 1'b0, 1'b0);
            tick();
        end
        drive('0, '0, '0, 1'b0, 1'b1, 1'b0);
        tick();
        grants = 0; deqs = 0; dones = 0; done_at = -1; done_seen = 0;
        for (int i = 0; i < 20; i++) begin
            drive(4'hF, NP*PW'($urandom), 16'h3210, 1'b0, 1'b0, 1'b0);
            if (done_seen) begin
                dones += int'(flush_done);
                chk("flush_resume_grant", 64'(enq_ready != 0), 64'd1);
                tick();
                break;
            end
            if (enq_ready != 0) grants++;
            if (pifo_deq) deqs++;
            if (flush_done) begin
                dones++;
                done_at   = i;
                done_seen = 1;
            end
            tick();
        end
        chk("flush_grants", 64'(grants), 64'd0);
        chk("flush_deqs", 64'(deqs), 64'd5);
        chk("flush_done_count", 64'(dones), 64'd1);
        chk("flush_done_cycle", 64'(done_at), 64'd5);

        // Reset while traffic is active.
        do_reset();
        for (int i = 0; i < 6; i++) begin
            drive(4'hF, NP*PW'($urandom), 16'h3210, 1'b1, 1'b0, 1'b0);
            tick();
        end
        drive(4'hF, NP*PW'($urandom), 16'h3210, 1'b1, 1'b0, 1'b1);
        tick();
        idle();
        chk("mid_rst_ready", 64'(enq_ready), 64'd0);
        chk("mid_rst_pifo_enq", 64'(pifo_enq), 64'd0);
        chk("mid_rst_pifo_deq", 64'(pifo_deq), 64'd0);
        chk("mid_rst_occ", 64'(occupancy), 64'd0);
        chk("mid_rst_deq_valid", 64'(deq_valid), 64'd0);
        chk("mid_rst_deq_prio", 64'(deq_prio), 64'd0);
        chk("mid_rst_deq_flow", 64'(deq_flow), 64'd0);
        chk("mid_rst_flush_done", 64'(flush_done), 64'd0);
        tick();
        drive(4'hF, NP*PW'($urandom), 16'h3210, 1'b0, 1'b0, 1'b0);
        chk("mid_rst_ptr0", 64'(enq_ready), 64'd1);
        tick();

        // Randomized traffic over a few flows so capacity limits are hit often.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            rpr = NP*PW'($urandom);
            for (int p = 0; p < NP; p++) rfl[p*FW +: FW] = FW'($urandom_range(0, 3));
            drive(NP'($urandom), rpr, rfl,
                  ($urandom % 10) < 4, ($urandom % 100) == 0, ($urandom % 600) == 0);
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/flow_pifo_ctrl.md
Name: flow_pifo_ctrl

Overview:
Front-end controller for flow_pifo. It arbitrates enqueue requests from NUM_PORTS ingress ports onto flow_pifo's single enqueue slot, using round-robin among eligible ports. It tracks per-flow and total occupancy so that no flow overruns its PIFO-set, prefetch and FIFO-bank storage, and it never dequeues an empty PIFO. It registers dequeue results toward the egress link and provides a flush mode that drains the PIFO.

Parameters:
NUM_PORTS, 4, number of ingress requesters
NUM_FLOWS, 16, number of flows; must match flow_pifo
FLOW_CAPACITY, 12, maximum packets resident per flow (1 PIFO-set entry + prefetch depth + FIFO depth)
PRIO_W, 8, priority width in bits
FLOW_W, 4, flow-id width; equals clog2(NUM_FLOWS)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
i__enq_valid  in  NUM_PORTS  per-port enqueue request
i__enq_priority  in  NUM_PORTS*PRIO_W  per-port priority, port p at bits [p*PRIO_W +: PRIO_W]
i__enq_flow_id  in  NUM_PORTS*FLOW_W  per-port flow id
o__enq_ready  out  NUM_PORTS  one-hot grant; transfer occurs when valid&ready
i__deq_req  in  1  egress requests one packet
i__flush  in  1  level; enter drain mode
o__deq_valid  out  1  registered dequeue result valid
o__deq_priority  out  PRIO_W  registered dequeued priority
o__deq_flow_id  out  FLOW_W  registered dequeued flow
o__pifo_enqueue  out  1  to flow_pifo i__enqueue
o__pifo_enqueue_priority  out  PRIO_W  to flow_pifo
o__pifo_enqueue_flow_id  out  FLOW_W  to flow_pifo
o__pifo_dequeue  out  1  to flow_pifo i__dequeue
i__pifo_dequeue_priority  in  PRIO_W  head priority from flow_pifo (combinational)
i__pifo_dequeue_flow_id  in  FLOW_W  head flow from flow_pifo
o__occupancy  out  clog2(NUM_FLOWS*FLOW_CAPACITY+1)  total resident packets
o__flush_done  out  1  one-cycle pulse when a flush completes

Behaviour:
- Reset values:
  - all counters 0; round-robin pointer 0; state RUN
  - o__deq_valid, o__flush_done 0; o__deq_priority, o__deq_flow_id 0
- State machine, RUN and FLUSH:
  - RUN -> FLUSH when i__flush=1.
  - FLUSH -> RUN when occupancy==0 and no dequeue is pending; o__flush_done pulses in that transition cycle.
  - If occupancy is already 0 when flush is requested, FLUSH lasts 1 cycle.
- Eligibility: port p is eligible when i__enq_valid[p], state==RUN, and flow_count[flow_id_p] < FLOW_CAPACITY. Counts are sampled before the current cycle's dequeue; there is no same-cycle credit.
- Grant:
  - Combinational, same cycle. Search begins at the pointer and wraps modulo NUM_PORTS; the first eligible port wins.
  - o__pifo_enqueue = |grant. Enqueue priority and flow id are muxed from the granted port.
  - Pointer updates to (granted+1) mod NUM_PORTS only on a grant; otherwise it holds.
  - Two ports targeting the same flow at count FLOW_CAPACITY-1: only the winner is granted this cycle. The loser sees the flow full next cycle.
- Dequeue:
  - o__pifo_dequeue = (i__deq_req in RUN, or unconditionally 1 in FLUSH) and occupancy != 0.
  - Requests while empty are dropped silently; o__deq_valid stays 0.
  - Head priority and flow are captured on the dequeue cycle. o__deq_valid and the data assert the next cycle for exactly 1 cycle per dequeue (latency 1).
- Counters:
  - flow_count[f] increments on enqueue to f and decrements on dequeue of f.
  - Simultaneous enqueue and dequeue of the same flow leaves the count unchanged. The total counter follows the same rule.
  - Counts never wrap: enqueue at FLOW_CAPACITY is blocked by eligibility; dequeue at 0 is blocked by the occupancy guard.
- i__flush held high across FLUSH->RUN re-enters FLUSH the next cycle.
- Reset mid-operation clears all state. Contents of flow_pifo are undefined unless flow_pifo is reset in the same cycle, so both share the reset.

Decomposition:
- Shared package (existing flow_pifo headers): Priority and FlowId typedefs, NUM_FLOWS, and the FLOW_CAPACITY derivation from PREFETCH_BUFFER_DEPTH and FIFO_DEPTH.
- Local: the two-state enum.
- Sub-module rr_arbiter (NUM_PORTS request vector in, one-hot grant out, pointer update on grant). It is reusable for later multi-port schedulers.

Test Plan:
- Ports 0-3 all valid with distinct flows 0-3, pointer 0 -> grants 0,1,2,3,0 on consecutive cycles; o__occupancy increments by 1 per cycle.
- Port 1 enqueues flow 5 twelve times, then a 13th request -> 13th not granted, flow_count[5]=12; one dequeue of flow 5 -> grant resumes the next cycle.
- Enqueue and dequeue of flow 2 in the same cycle at count 3 -> count stays 3, total unchanged, o__deq_valid=1 next cycle with captured priority.
- i__deq_req with occupancy 0 -> o__pifo_dequeue=0, o__deq_valid=0 next cycle.
- 5 packets resident, pulse i__flush -> no grants, 5 consecutive dequeues, o__flush_done pulses once, return to RUN.
- Reset asserted while grants and dequeues are active -> all outputs 0 next cycle, pointer 0, occupancy 0.
